rx_pkt_rcu: RTL

Parametrised receiver control unit for the USB-style serial receiver. It sits between the shift register/edge detector/EOP detector and the RX FIFO. Beyond basic sync/read/write sequencing, it adds:
- configurable sync pattern;
- optional PID complement check;
- byte counting with maximum-length enforcement;
- FIFO-overflow detection;
- byte-aligned EOP checking with a minimum EOP width;
- an encoded, sticky error code and a packet-done pulse with length.

---
 rtl/rx_pkt_rcu_pkg.sv | 30 +++
 rtl/rx_pkt_rcu_if.sv | 29 ++
 rtl/rx_pkt_rcu_flex_counter.sv | 22 ++
 rtl/rx_pkt_rcu.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/rx_pkt_rcu_pkg.sv
// Shared types and helpers for the receiver control unit.
package rx_pkt_rcu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PID,
        READ,
        WRITE,
        EOP,
        ERR,
        EIDLE
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_BAD_SYNC   = 3'd1,
        ERR_BAD_PID    = 3'd2,
        ERR_EARLY_EOP  = 3'd3,
        ERR_OVERLENGTH = 3'd4,
        ERR_OVERFLOW   = 3'd5,
        ERR_BAD_EOP    = 3'd6
    } err_t;

    // A PID byte carries its own complement in the low nibble.
    function automatic logic pid_ok(input logic [7:0] pid_byte);
        return pid_byte[3:0] == ~pid_byte[7:4];
    endfunction

endpackage

// File: rtl/rx_pkt_rcu_if.sv
// Bus between the receive datapath/FIFO side and the receiver control unit.
interface rx_pkt_rcu_if #(
    parameter int MAX_BYTES = 64
);
    localparam int CNT_W = $clog2(MAX_BYTES + 1);

    logic             d_edge;
    logic             eop;
    logic             shift_enable;
    logic [7:0]       rcv_data;
    logic             byte_received;
    logic             fifo_full;
    logic             rcving;
    logic             w_enable;
    logic             r_error;
    logic [2:0]       err_code;
    logic             pkt_done;
    logic [CNT_W-1:0] pkt_len;

    modport master (
        output d_edge, eop, shift_enable, rcv_data, byte_received, fifo_full,
        input  rcving, w_enable, r_error, err_code, pkt_done, pkt_len
    );

    modport slave (
        input  d_edge, eop, shift_enable, rcv_data, byte_received, fifo_full,
        output rcving, w_enable, r_error, err_code, pkt_done, pkt_len
    );
endinterface

// File: rtl/rx_pkt_rcu_flex_counter.sv
// Up-counter with synchronous clear; used to count bytes written per packet.
module rx_pkt_rcu_flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    // Clear has priority so a new packet always starts from zero.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            count_out <= '0;
        else if (clear)
            count_out <= '0;
        else if (count_enable)
            count_out <= count_out + 1'b1;
    end

endmodule

// File: rtl/rx_pkt_rcu.sv
// Receiver control unit: sync/PID checking, FIFO write sequencing,
// length limiting, EOP qualification and sticky error reporting.
module rx_pkt_rcu
    import rx_pkt_rcu_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         MAX_BYTES = 64,
    parameter bit         PID_CHECK = 1'b1,
    parameter int         EOP_BITS  = 2
) (
    input  logic     clk,
    input  logic     n_rst,
    rx_pkt_rcu_if.slave bus
);

    localparam int                CNT_W   = $clog2(MAX_BYTES + 1);
    localparam int                EOP_W   = $clog2(EOP_BITS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BYTES);
    localparam logic [EOP_W-1:0]  EOP_MAX = EOP_W'(EOP_BITS);

    state_t           state;
    state_t           next_state;
    err_t             err_code;
    err_t             next_err;
    logic             bits_pending;
    logic [EOP_W-1:0] eop_cnt;
    logic             eop_cnt_clear;
    logic [CNT_W-1:0] byte_cnt;
    logic             cnt_clear;
    logic             w_enable;
    logic             pkt_done;

    rx_pkt_rcu_flex_counter #(
        .NUM_CNT_BITS(CNT_W)
    ) u_byte_cnt (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (cnt_clear),
        .count_enable(w_enable),
        .count_out   (byte_cnt)
    );

    // State and sticky error code registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            err_code <= ERR_NONE;
        end else begin
            state    <= next_state;
            err_code <= next_err;
        end
    end

    // Tracks a partially shifted byte; a new bit outranks a completed byte.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            bits_pending <= 1'b0;
        else if (bus.shift_enable)
            bits_pending <= 1'b1;
        else if (bus.byte_received)
            bits_pending <= 1'b0;
    end

    // Measures EOP width in bit times, saturating once the minimum is met.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            eop_cnt <= '0;
        else if (eop_cnt_clear)
            eop_cnt <= '0;
        else if (state == EOP && bus.eop && bus.shift_enable && eop_cnt < EOP_MAX)
            eop_cnt <= eop_cnt + 1'b1;
    end

    // Next-state, error-code update and strobe generation.
    always_comb begin
        next_state    = state;
        next_err      = err_code;
        w_enable      = 1'b0;
        pkt_done      = 1'b0;
        cnt_clear     = 1'b0;
        eop_cnt_clear = 1'b0;
        case (state)
            IDLE: begin
                if (bus.d_edge) begin
                    next_state = SYNC;
                    next_err   = ERR_NONE;
                    cnt_clear  = 1'b1;
                end
            end
            SYNC: begin
                if (bus.eop) begin
                    next_state = EIDLE;
                    next_err   = ERR_EARLY_EOP;
                end else if (bus.byte_received) begin
                    if (bus.rcv_data == SYNC_BYTE) begin
                        next_state = PID;
                    end else begin
                        next_state = ERR;
                        next_err   = ERR_BAD_SYNC;
                    end
                end
            end
            PID: begin
                if (bus.eop) begin
                    next_state = EIDLE;
                    next_err   = ERR_EARLY_EOP;
                end else if (bus.byte_received) begin
                    if (!PID_CHECK || pid_ok(bus.rcv_data)) begin
                        next_state = WRITE;
                    end else begin
                        next_state = ERR;
                        next_err   = ERR_BAD_PID;
                    end
                end
            end
            READ: begin
                if (bus.eop && (bits_pending || bus.byte_received)) begin
                    next_state = EIDLE;
                    next_err   = ERR_EARLY_EOP;
                end else if (bus.eop) begin
                    next_state    = EOP;
                    eop_cnt_clear = 1'b1;
                end else if (bus.byte_received) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (byte_cnt == CNT_MAX) begin
                    next_state = ERR;
                    next_err   = ERR_OVERLENGTH;
                end else if (bus.fifo_full) begin
                    next_state = ERR;
                    next_err   = ERR_OVERFLOW;
                end else begin
                    w_enable   = 1'b1;
                    next_state = READ;
                end
            end
            EOP: begin
                if (!bus.eop) begin
                    if (eop_cnt >= EOP_MAX) begin
                        next_state = IDLE;
                        pkt_done   = 1'b1;
                    end else begin
                        next_state = EIDLE;
                        next_err   = ERR_BAD_EOP;
                    end
                end
            end
            ERR: begin
                if (bus.eop)
                    next_state = EIDLE;
            end
            EIDLE: begin
                if (bus.d_edge) begin
                    next_state = SYNC;
                    next_err   = ERR_NONE;
                    cnt_clear  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.rcving   = (state != IDLE) && (state != EIDLE);
    assign bus.r_error  = (state == ERR) || (state == EIDLE);
    assign bus.err_code = err_code;
    assign bus.w_enable = w_enable;
    assign bus.pkt_done = pkt_done;
    assign bus.pkt_len  = byte_cnt;

endmodule
